// File: rtl/round_pkg.sv
// Shared types and defaults for the round_quant scale/round/saturate pipeline.
// Frame length defaults to SASA_Input_len when the build defines it.
`ifndef SASA_Input_len
`define SASA_Input_len 256
`endif

package round_pkg;

  typedef enum logic [1:0] {
    TRUNC     = 2'd0,
    HALF_AWAY = 2'd1,
    HALF_EVEN = 2'd2,
    LEGACY    = 2'd3
  } round_mode_e;

  localparam int DEFAULT_LEN = `SASA_Input_len;

endpackage

// File: rtl/mul_shift_stage.sv
// First pipeline stage: signed multiply by scale, then arithmetic right shift.
// The product register loads only when the top accepts a beat.
module mul_shift_stage #(
  parameter int DATA_W  = 32,
  parameter int SCALE_W = 16,
  parameter int SHIFT   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load,
  input  logic signed [DATA_W-1:0]          in_data,
  input  logic signed [SCALE_W-1:0]         scale,
  output logic signed [DATA_W+SCALE_W-1:0]  p
);

  localparam int PW = DATA_W + SCALE_W;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] s_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  assign a_x     = PW'(in_data);
  assign s_x     = PW'(scale);
  assign prod    = a_x * s_x;
  assign shifted = prod >>> SHIFT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p <= '0;
    end else if (load) begin
      p <= shifted;
    end
  end

endmodule

// File: rtl/round_quant.sv
// Two-stage elastic pipeline: scale/shift, then divide, round and saturate.
// Each beat carries its rounding mode and frame-last tag down the pipe.
module round_quant
  import round_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SCALE_W = 16,
  parameter int SHIFT   = 8,
  parameter int DIV     = 10,
  parameter int OUT_W   = 32,
  parameter int LEN     = DEFAULT_LEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [SCALE_W-1:0] scale,
  input  logic [1:0]                mode,
  input  logic                      frame_clr,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      out_sat
);

  localparam int PW    = DATA_W + SCALE_W;
  localparam int CW    = ((PW > OUT_W) ? PW : OUT_W) + 1;
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(LEN - 1);
  localparam logic signed [PW-1:0] DIV_S   = PW'(DIV);
  localparam logic signed [PW-1:0] ONE     = PW'(1);
  localparam logic signed [CW-1:0] OMAX    =
    {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] OMIN    =
    {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                 s1_valid;
  logic                 s1_last;
  round_mode_e          s1_mode;
  logic signed [PW-1:0] p;
  logic                 s2_ready;
  logic                 accept;

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     idx;
  logic                 beat_last;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = reset && (!s1_valid || s2_ready);
  assign accept   = in_valid && in_ready;

  // A clear in the same cycle as an accept makes that beat index 0.
  assign idx       = frame_clr ? '0 : cnt;
  assign beat_last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= beat_last ? '0 : idx + 1'b1;
    end else if (frame_clr) begin
      cnt <= '0;
    end
  end

  mul_shift_stage #(
    .DATA_W  (DATA_W),
    .SCALE_W (SCALE_W),
    .SHIFT   (SHIFT)
  ) u_s1 (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .in_data (in_data),
    .scale   (scale),
    .p       (p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= TRUNC;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= beat_last;
        s1_mode <= round_mode_e'(mode);
      end
    end
  end

  logic signed [PW-1:0] q;
  logic signed [PW-1:0] r;
  logic signed [PW-1:0] abs_r;
  logic [PW:0]          two_r;
  logic [PW:0]          div_x;
  logic                 bump;
  logic signed [PW-1:0] qr;
  logic signed [CW-1:0] qx;
  logic signed [OUT_W-1:0] sat_val;
  logic                 sat;

  assign q     = p / DIV_S;
  assign r     = p - q * DIV_S;
  assign abs_r = r[PW-1] ? -r : r;
  assign two_r = {abs_r, 1'b0};
  assign div_x = {1'b0, DIV_S};

  always_comb begin
    bump = 1'b0;
    unique case (s1_mode)
      TRUNC:     bump = 1'b0;
      HALF_AWAY: bump = (two_r >= div_x);
      HALF_EVEN: bump = (two_r > div_x) || ((two_r == div_x) && q[0]);
      LEGACY:    bump = (two_r > div_x);
      default:   bump = 1'b0;
    endcase
  end

  always_comb begin
    qr = q;
    if (bump) begin
      qr = p[PW-1] ? q - ONE : q + ONE;
    end
    qx      = {{(CW-PW){qr[PW-1]}}, qr};
    sat     = 1'b0;
    sat_val = qx[OUT_W-1:0];
    if (qx > OMAX) begin
      sat     = 1'b1;
      sat_val = OMAX[OUT_W-1:0];
    end else if (qx < OMIN) begin
      sat     = 1'b1;
      sat_val = OMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_val;
        out_last <= s1_last;
        out_sat  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_round_quant.sv
// Directed bench for round_quant with a scoreboard driven by an arithmetic model.
// Config: SCALE=1, SHIFT=0, DIV=10, OUT_W=8, LEN=4.
module tb_round_quant;

  localparam int DIV = 10;
  localparam int LEN = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] scale = 16'sd1;
  logic [1:0]         mode = 2'd0;
  logic               frame_clr = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_last;
  logic               out_sat;

  round_quant #(
    .DATA_W(32), .SCALE_W(16), .SHIFT(0),
    .DIV(DIV), .OUT_W(8), .LEN(LEN)
  ) dut (
    .clk(clk), .reset(reset), .scale(scale), .mode(mode),
    .frame_clr(frame_clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: round |p|/DIV by magnitude, reapply sign, clip to 8 bits.
  function automatic void model(input longint d, input int m,
                                output int v, output bit s);
    longint p, a, q0, r, mag, res;
    bit up;
    p = d * longint'(scale);
    a = (p < 0) ? -p : p;
    q0 = a / DIV;
    r = a % DIV;
    case (m)
      1: up = (2 * r >= DIV);
      2: up = (2 * r > DIV) || ((2 * r == DIV) && (q0 % 2 == 1));
      3: up = (2 * r > DIV);
      default: up = 1'b0;
    endcase
    mag = q0 + (up ? 1 : 0);
    res = (p < 0) ? -mag : mag;
    s = 1'b0;
    if (res > 127) begin res = 127; s = 1'b1; end
    if (res < -128) begin res = -128; s = 1'b1; end
    v = int'(res);
  endfunction

  typedef struct {
    int d;
    bit s;
    bit l;
  } exp_t;

  exp_t sbq[$];
  int   mcnt = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   n_last = 0;
  int   last_at = 0;
  bit   held = 1'b0;
  logic signed [7:0] h_data;
  logic h_last, h_sat;

  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      mcnt = 0;
      held = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_sat", out_sat, e.s);
          chk("sb_last", out_last, e.l);
        end
        n_out++;
        if (out_last) begin
          n_last++;
          last_at = n_out;
        end
      end
      if (out_valid && !out_ready) begin
        if (held) begin
          chk("hold_data", out_data, h_data);
          chk("hold_last", out_last, h_last);
          chk("hold_sat", out_sat, h_sat);
        end
        held = 1'b1;
        h_data = out_data;
        h_last = out_last;
        h_sat = out_sat;
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int bidx;
        bidx = frame_clr ? 0 : mcnt;
        model(longint'(in_data), int'(mode), e.d, e.s);
        e.l = (bidx == LEN - 1);
        mcnt = e.l ? 0 : bidx + 1;
        sbq.push_back(e);
        n_in++;
      end else if (frame_clr) begin
        mcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int d, input int m, input int ed,
                          input bit es, input string nm);
    int k;
    in_data = d;
    mode = m[1:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    chk({nm, "_timeout"}, (k < 10), 1);
    chk({nm, "_data"}, out_data, ed);
    chk({nm, "_sat"}, out_sat, es);
    tick();
  endtask

  task automatic stream(input int nb, input int clr_at, input int base);
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1;
      in_data = base + 9 * i;
      mode = 2'(i);
      frame_clr = (i == clr_at);
      tick();
    end
    in_valid = 1'b0;
    frame_clr = 1'b0;
  endtask

  initial begin
    int nb, n0, l0, i0;
    bit a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    send_one(-15, 0, -1, 0, "m15_trunc");
    send_one(-15, 1, -2, 0, "m15_away");
    send_one(-15, 2, -2, 0, "m15_even");
    send_one(-15, 3, -1, 0, "m15_legacy");
    send_one(-25, 1, -3, 0, "m25_away");
    send_one(-25, 2, -2, 0, "m25_even");
    send_one(-25, 3, -2, 0, "m25_legacy");
    send_one(-26, 0, -2, 0, "m26_trunc");
    send_one(-26, 1, -3, 0, "m26_away");
    send_one(2000, 1, 127, 1, "sat_pos");
    send_one(-2000, 1, -128, 1, "sat_neg");
    send_one(35, 2, 4, 0, "p35_even");

    // Burst of eight: latency, no bubbles, last on beats 4 and 8.
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    n0 = n_out;
    l0 = n_last;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = -60 + 17 * i;
      mode = 2'(i);
      tick();
      if (i == 0) chk("lat_early", out_valid, 0);
      if (i == 1) chk("lat_rise", out_valid, 1);
      if (i >= 1) nb += int'(out_valid);
    end
    in_valid = 1'b0;
    tick();
    nb += int'(out_valid);
    chk("no_bubble", nb, 8);
    repeat (3) tick();
    chk("burst_nlast", n_last - l0, 2);
    chk("burst_last_at", last_at - n0, 8);

    // Backpressure with a continuous input stream.
    n0 = n_out;
    i0 = n_in;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = -100;
    mode = 2'd1;
    for (int c = 0; c < 11; c++) begin
      if (c == 5) out_ready = 1'b1;
      if (c == 1) chk("bp_ready_c1", in_ready, 1);
      if (c == 2) chk("bp_ready_fall", in_ready, 0);
      if (c == 4) chk("bp_ready_low", in_ready, 0);
      a = in_ready;
      tick();
      if (a) begin
        in_data = in_data + 23;
        mode = mode + 2'd1;
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_count", n_out - n0, n_in - i0);
    chk("bp_sb_empty", sbq.size(), 0);

    // frame_clr on the third beat restarts the index.
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    n0 = n_out;
    l0 = n_last;
    stream(6, 2, 41);
    repeat (4) tick();
    chk("clr_nlast", n_last - l0, 1);
    chk("clr_last_at", last_at - n0, 6);

    // Reset mid-frame with beats stalled in flight.
    out_ready = 1'b0;
    stream(2, -1, 7);
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    n0 = n_out;
    l0 = n_last;
    stream(4, -1, -33);
    repeat (4) tick();
    chk("rst_nlast", n_last - l0, 1);
    chk("rst_last_at", last_at - n0, 4);
    chk("rst_count", n_out - n0, 4);
    chk("final_sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
